// File: rtl/address_generator_pkg.sv
// Shared definitions for the SRAM address generator: operation modes, controller
// states, ciphertext row length and small elaboration-time helpers.
package address_generator_pkg;

    typedef enum logic [1:0] {
        MODE_ENCRYPT  = 2'b00,
        MODE_DECRYPT  = 2'b01,
        MODE_ADD      = 2'b10,
        MODE_MULTIPLY = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam int DEFAULT_DIMENSION = 10;
    // A ciphertext row holds DIMENSION mask words plus one body word.
    localparam int ROW_LEN = DEFAULT_DIMENSION + 1;

    function automatic int row_len(input int dimension);
        return dimension + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/address_generator_addr_seq_counter.sv
// Nested outer/inner counter with runtime limits; the inner index wraps to zero
// and bumps the outer index, both wrap together after the final position.
module addr_seq_counter
    import address_generator_pkg::*;
#(
    parameter int OUTER_W = 5,
    parameter int INNER_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [OUTER_W-1:0] outer_max_i,
    input  logic [INNER_W-1:0] inner_max_i,
    output logic [OUTER_W-1:0] outer_o,
    output logic [INNER_W-1:0] inner_o,
    output logic               inner_last_o,
    output logic               outer_last_o
);

    logic [OUTER_W-1:0] outer_q, outer_d;
    logic [INNER_W-1:0] inner_q, inner_d;

    assign inner_last_o = (inner_q == inner_max_i);
    assign outer_last_o = (outer_q == outer_max_i);
    assign outer_o      = outer_q;
    assign inner_o      = inner_q;

    always_comb begin
        outer_d = outer_q;
        inner_d = inner_q;
        if (clear_i) begin
            outer_d = '0;
            inner_d = '0;
        end else if (advance_i) begin
            if (inner_last_o) begin
                inner_d = '0;
                outer_d = outer_last_o ? '0 : outer_q + 1'b1;
            end else begin
                inner_d = inner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

endmodule

// File: rtl/address_generator.sv
// Walks operand SRAM regions for LWE encrypt/decrypt/add/multiply, issuing one read
// per ready cycle and tagging each returned word with row/column/operand metadata.
module address_generator
    import address_generator_pkg::*;
#(
    parameter int  DIMENSION  = ROW_LEN - 1,
    parameter int  BIG_N      = 30,
    parameter int  ADDR_WIDTH = 10,
    localparam int ROW_LEN_P  = row_len(DIMENSION),
    localparam int ROW_W      = width_of(max_int(BIG_N, ROW_LEN_P)),
    localparam int COL_W      = width_of(ROW_LEN_P)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] op1_base_addr,
    input  logic [ADDR_WIDTH-1:0] op2_base_addr,
    input  logic                  ready,
    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  data_valid,
    output logic [ROW_W-1:0]      row,
    output logic [COL_W-1:0]      col,
    output logic                  op_select,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    // Inner index must reach ROW_LEN for multiply (one op1 word + ROW_LEN op2 words).
    localparam int IW = width_of(ROW_LEN_P + 1);

    state_e                state_q;
    logic                  done_q;
    mode_e                 mode_q;
    logic [ADDR_WIDTH-1:0] op1_q;
    logic [ADDR_WIDTH-1:0] op2_q;

    logic                  dv_q;
    logic                  last_q;
    logic                  op_sel_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;

    logic                  issue;
    logic                  seq_last;
    logic                  inner_last;
    logic                  outer_last;
    logic [ROW_W-1:0]      outer_cnt;
    logic [ROW_W-1:0]      outer_max;
    logic [IW-1:0]         inner_cnt;
    logic [IW-1:0]         inner_max;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ROW_W-1:0]      row_d;
    logic [COL_W-1:0]      col_d;
    logic                  op_sel_d;

    assign issue    = (state_q == ST_RUN) && ready;
    assign seq_last = inner_last && outer_last;

    addr_seq_counter #(
        .OUTER_W (ROW_W),
        .INNER_W (IW)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q != ST_RUN),
        .advance_i    (issue),
        .outer_max_i  (outer_max),
        .inner_max_i  (inner_max),
        .outer_o      (outer_cnt),
        .inner_o      (inner_cnt),
        .inner_last_o (inner_last),
        .outer_last_o (outer_last)
    );

    // Loop bounds per mode: outer index is row (or column for add), inner is word slot.
    always_comb begin
        outer_max = '0;
        inner_max = '0;
        case (mode_q)
            MODE_ENCRYPT: begin
                outer_max = ROW_W'(BIG_N - 1);
                inner_max = IW'(DIMENSION);
            end
            MODE_DECRYPT: begin
                inner_max = IW'(DIMENSION);
            end
            MODE_ADD: begin
                outer_max = ROW_W'(DIMENSION);
                inner_max = IW'(1);
            end
            default: begin
                outer_max = ROW_W'(DIMENSION);
                inner_max = IW'(ROW_LEN_P);
            end
        endcase
    end

    // Address and tags of the word issued this cycle; sums wrap at ADDR_WIDTH.
    always_comb begin
        addr_d   = op1_q;
        row_d    = outer_cnt;
        col_d    = COL_W'(inner_cnt);
        op_sel_d = 1'b0;
        case (mode_q)
            MODE_ENCRYPT: begin
                addr_d = op1_q + ADDR_WIDTH'(outer_cnt) * ADDR_WIDTH'(ROW_LEN_P)
                               + ADDR_WIDTH'(inner_cnt);
            end
            MODE_DECRYPT: begin
                addr_d = op1_q + ADDR_WIDTH'(inner_cnt);
                row_d  = '0;
            end
            MODE_ADD: begin
                op_sel_d = inner_cnt[0];
                addr_d   = (inner_cnt[0] ? op2_q : op1_q) + ADDR_WIDTH'(outer_cnt);
                row_d    = '0;
                col_d    = COL_W'(outer_cnt);
            end
            default: begin
                if (inner_cnt == '0) begin
                    addr_d = op1_q + ADDR_WIDTH'(outer_cnt);
                    col_d  = '0;
                end else begin
                    op_sel_d = 1'b1;
                    addr_d   = op2_q + ADDR_WIDTH'(inner_cnt - IW'(1));
                    col_d    = COL_W'(inner_cnt - IW'(1));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            mode_q  <= MODE_ENCRYPT;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // The done cycle still counts as busy, so start is refused then.
                        if (start && !done_q) begin
                            state_q <= ST_RUN;
                            mode_q  <= mode_e'(mode);
                            op1_q   <= op1_base_addr;
                            op2_q   <= op2_base_addr;
                        end
                    end
                    ST_RUN: begin
                        if (issue && seq_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // One-cycle read latency: tags follow the issue by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q     <= 1'b0;
            last_q   <= 1'b0;
            op_sel_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            dv_q     <= issue;
            last_q   <= issue && seq_last && !abort;
            op_sel_q <= issue ? op_sel_d : 1'b0;
            row_q    <= issue ? row_d : '0;
            col_q    <= issue ? col_d : '0;
        end
    end

    assign sram_rd_en = issue;
    assign sram_addr  = issue ? addr_d : '0;
    assign data_valid = dv_q;
    assign row        = row_q;
    assign col        = col_q;
    assign op_select  = op_sel_q;
    assign last       = last_q;
    assign busy       = (state_q != ST_IDLE) || done_q;
    assign done       = done_q;

endmodule
